// File: rtl/sub_div_ctrl.sv
// sub_div_ctrl: sequential restoring-division controller.
// Accepts a dividend/divisor pair on start and runs WIDTH trial subtractions,
// one per clock, on a WIDTH+1-bit ripple subtractor (a - b - borrow_in).
// It then registers quotient/remainder and pulses done for one cycle.
// Divide-by-zero completes in one cycle with quotient all ones and
// remainder equal to the dividend.
// Optional feature macro: SUB_DIV_SIGNED_EN (two's-complement operands;
// magnitudes are divided and the result signs are fixed up at registration).
module sub_div_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;          // partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // dividend / quotient shift register
  logic [WIDTH-1:0] d_q, d_d;          // divisor
  logic [CW-1:0]    cnt_q, cnt_d;      // remaining steps
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

`ifdef SUB_DIV_SIGNED_EN
  logic             neg_quot_q, neg_quot_d;  // operand signs differed
  logic             neg_rem_q, neg_rem_d;    // dividend was negative

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + ONE;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Trial-subtraction datapath: T - {0,D} with borrow_in = 0.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   t_vec;
  logic [WIDTH:0]   s_vec;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] brw;
  logic             borrow_out;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  // The restored/difference value always stays below the divisor, so the
  // top bit of P never reaches the next trial operand.
  logic             unused_p_msb;
  assign unused_p_msb = p_q[WIDTH];

  assign t_vec  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign s_vec  = {1'b0, d_q};
  assign brw[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
      assign diff[gi]    = t_vec[gi] ^ s_vec[gi] ^ brw[gi];
      assign brw[gi + 1] = (~t_vec[gi] & s_vec[gi]) |
                           (~(t_vec[gi] ^ s_vec[gi]) & brw[gi]);
    end
  endgenerate

  assign borrow_out = brw[WIDTH+1];

  // Restore on borrow, otherwise keep the difference; shift in the quotient bit.
  always_comb begin
    p_next = borrow_out ? t_vec : diff;
    q_next = {q_q[WIDTH-2:0], ~borrow_out};
  end

  // ---------------------------------------------------------------------
  // Operand conditioning at load and result conditioning at completion.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] dvd_load;
  logic [WIDTH-1:0] dvs_load;
  logic [WIDTH-1:0] quot_res;
  logic [WIDTH-1:0] rem_res;

  // Magnitudes go into the iteration; sign fix-up is applied to the results.
  always_comb begin
`ifdef SUB_DIV_SIGNED_EN
    dvd_load = dividend[WIDTH-1] ? negate(dividend) : dividend;
    dvs_load = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
    quot_res = neg_quot_q ? negate(q_next) : q_next;
    rem_res  = neg_rem_q  ? negate(p_next[WIDTH-1:0]) : p_next[WIDTH-1:0];
`else
    dvd_load = dividend;
    dvs_load = divisor;
    quot_res = q_next;
    rem_res  = p_next[WIDTH-1:0];
`endif
  end

  // ---------------------------------------------------------------------
  // Control: next-state, operand sequencing and result registration.
  // ---------------------------------------------------------------------
  // All state holds by default; only accepted starts and BUSY steps change it.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SUB_DIV_SIGNED_EN
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            // No iteration: report immediately.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = BUSY;
            p_d     = '0;
            q_d     = dvd_load;
            d_d     = dvs_load;
            cnt_d   = CW'(WIDTH);
`ifdef SUB_DIV_SIGNED_EN
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
`endif
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // start is deliberately ignored here.
        p_d   = p_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = quot_res;
          remainder_d = rem_res;
          dbz_d       = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SUB_DIV_SIGNED_EN
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef SUB_DIV_SIGNED_EN
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  // Status flags follow the registered state directly.
  always_comb begin
    busy        = (state_q == BUSY);
    done        = (state_q == DONE);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule
